// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, header width and the frame-length
// helper used by both the transmit and receive sides of the link.
package uart_pkg;

  localparam int HDR_BITS = 4;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_HEADER = 3'd1;
  localparam state_t S_START  = 3'd2;
  localparam state_t S_DATA   = 3'd3;
  localparam state_t S_PARITY = 3'd4;
  localparam state_t S_STOP   = 3'd5;

  // Bits on the line for one frame, excluding the one-time header.
  function automatic int frame_len(input int data_len, input int parity_en);
    return data_len + parity_en + 2;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts CLKS_PER_BIT cycles while enabled and pulses
// o_tick on the last cycle of each period.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic srst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (srst || i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en & w_last;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: serialises one word per frame (start/data/parity/stop),
// preceded by a 4-bit frame-length header on the first frame after reset.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DATA_LENGTH  = 8,
  parameter int PARITY_EN    = 1,
  parameter int CLKS_PER_BIT = 10
) (
  input  logic                   tx_clk,
  input  logic                   rst,
  input  logic                   tx_start,
  input  logic [DATA_LENGTH-1:0] parallel_datain,
  input  logic                   parity_type,
  output logic                   tx_ready,
  output logic                   serialdata_out,
  output logic                   tx_done,
  output logic                   baudratetx
);

  localparam int                  FRAME_LEN = frame_len(DATA_LENGTH, PARITY_EN);
  localparam logic [HDR_BITS-1:0] HDR_WORD  = HDR_BITS'(FRAME_LEN);

  state_t                r_state;
  logic                  r_line;
  logic                  r_hdr_pending;
  logic [HDR_BITS-1:0]   r_hdr_shift;
  logic [DATA_LENGTH-1:0] r_data;
  logic                  r_parity_bit;
  logic [3:0]            r_bit_cnt;

  logic w_idle;
  logic w_accept;
  logic w_tick;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle & tx_start;

  // Divider only runs while a frame is in flight, so no ticks appear in IDLE.
  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (tx_clk),
    .srst   (rst),
    .i_clear(w_accept),
    .i_en   (~w_idle),
    .o_tick (w_tick)
  );

  always_ff @(posedge tx_clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_line        <= 1'b1;
      r_hdr_pending <= 1'b1;
      r_hdr_shift   <= '0;
      r_data        <= '0;
      r_parity_bit  <= 1'b0;
      r_bit_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (tx_start) begin
            r_data       <= parallel_datain;
            r_parity_bit <= (^parallel_datain) ^ parity_type;
            r_bit_cnt    <= '0;
            if (r_hdr_pending) begin
              r_state     <= S_HEADER;
              r_line      <= HDR_WORD[HDR_BITS-1];
              r_hdr_shift <= HDR_WORD << 1;
            end else begin
              r_state <= S_START;
              r_line  <= 1'b0;
            end
          end
        end
        S_HEADER: begin
          if (w_tick) begin
            if (r_bit_cnt == 4'(HDR_BITS - 1)) begin
              r_state       <= S_START;
              r_line        <= 1'b0;
              r_bit_cnt     <= '0;
              r_hdr_pending <= 1'b0;
            end else begin
              r_line      <= r_hdr_shift[HDR_BITS-1];
              r_hdr_shift <= r_hdr_shift << 1;
              r_bit_cnt   <= r_bit_cnt + 1'b1;
            end
          end
        end
        S_START: begin
          if (w_tick) begin
            r_state   <= S_DATA;
            r_line    <= r_data[0];
            r_data    <= r_data >> 1;
            r_bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_bit_cnt == 4'(DATA_LENGTH - 1)) begin
              r_bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                r_state <= S_PARITY;
                r_line  <= r_parity_bit;
              end else begin
                r_state <= S_STOP;
                r_line  <= 1'b1;
              end
            end else begin
              r_line    <= r_data[0];
              r_data    <= r_data >> 1;
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_state <= S_STOP;
            r_line  <= 1'b1;
          end
        end
        S_STOP: begin
          // Line is already high; the next IDLE cycle shows it as the gap bit.
          if (w_tick) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_line  <= 1'b1;
        end
      endcase
    end
  end

  assign serialdata_out = r_line;
  assign tx_ready       = w_idle;
  assign tx_done        = w_idle;
  assign baudratetx     = w_tick;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: two configurations (8E with
// divide-by-10, 7-bit no-parity with divide-by-4) against a bit-list model.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ptype = 1'b0;

  logic start1, start2;
  logic line1, done1, ready1, baud1;
  logic line2, done2, ready2, baud2;
  logic line, done, ready, baud;

  int n_checks = 0;
  int n_errors = 0;
  bit exp_bits[$];
  bit hdr_pend[2] = '{1'b1, 1'b1};

  always #5 clk = ~clk;

  assign start1 = start & ~sel;
  assign start2 = start & sel;
  assign line   = sel ? line2  : line1;
  assign done   = sel ? done2  : done1;
  assign ready  = sel ? ready2 : ready1;
  assign baud   = sel ? baud2  : baud1;

  uart_transmitter #(.DATA_LENGTH(8), .PARITY_EN(1), .CLKS_PER_BIT(10)) dut1 (
    .tx_clk(clk), .rst(rst), .tx_start(start1), .parallel_datain(data_in),
    .parity_type(ptype), .tx_ready(ready1), .serialdata_out(line1),
    .tx_done(done1), .baudratetx(baud1)
  );

  uart_transmitter #(.DATA_LENGTH(7), .PARITY_EN(0), .CLKS_PER_BIT(4)) dut2 (
    .tx_clk(clk), .rst(rst), .tx_start(start2), .parallel_datain(data_in[6:0]),
    .parity_type(ptype), .tx_ready(ready2), .serialdata_out(line2),
    .tx_done(done2), .baudratetx(baud2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int cur_cpb();
    return sel ? 4 : 10;
  endfunction

  // Reference frame as a list of line bits, built from the frame rules.
  task automatic build_expected(input logic [7:0] d, input logic pt);
    int dl, pe, fl, ones;
    bit b;
    dl = sel ? 7 : 8;
    pe = sel ? 0 : 1;
    fl = dl + pe + 2;
    exp_bits.delete();
    if (hdr_pend[int'(sel)]) begin
      for (int i = 0; i < 4; i++) exp_bits.push_back(bit'((fl >> (3 - i)) & 1));
      hdr_pend[int'(sel)] = 1'b0;
    end
    exp_bits.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < dl; i++) begin
      b = bit'((int'(d) >> i) & 1);
      ones += int'(b);
      exp_bits.push_back(b);
    end
    if (pe != 0) begin
      if (pt) exp_bits.push_back((ones % 2) == 0);
      else    exp_bits.push_back((ones % 2) == 1);
    end
    exp_bits.push_back(1'b1);
  endtask

  task automatic accept(input string tag, input logic [7:0] d, input logic pt);
    int w;
    w = 0;
    while (!ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " ready_wait"}, 32'(ready), 32'd1);
    data_in = d;
    ptype   = pt;
    start   = 1'b1;
    build_expected(d, pt);
    @(posedge clk);
  endtask

  task automatic check_frame(input string tag, input int stop_at, input int inject_at,
                             input logic [7:0] inj_d);
    int cpb, n;
    logic tick_exp;
    cpb = cur_cpb();
    n = exp_bits.size() * cpb;
    if (stop_at >= 0 && stop_at < n) n = stop_at;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (k == inject_at) begin
        start   = 1'b1;
        data_in = inj_d;
        ptype   = ~ptype;
      end
      tick_exp = ((k % cpb) == cpb - 1);
      chk($sformatf("%s cyc%0d line/done/ready/baud", tag, k),
          32'({line, done, ready, baud}), 32'({exp_bits[k / cpb], 2'b00, tick_exp}));
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk(tag, 32'({line, done, ready, baud}), 32'(4'b1110));
  endtask

  task automatic reset_pulse(input string tag);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk({tag, " dut1"}, 32'({line1, done1, ready1, baud1}), 32'(4'b1110));
    chk({tag, " dut2"}, 32'({line2, done2, ready2, baud2}), 32'(4'b1110));
    rst = 1'b0;
    hdr_pend = '{1'b1, 1'b1};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       pt;
    int         gap;

    // 1: reset held three cycles
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1 dut1 reset", 32'({line1, done1, ready1, baud1}), 32'(4'b1110));
    chk("t1 dut2 reset", 32'({line2, done2, ready2, baud2}), 32'(4'b1110));
    rst = 1'b0;
    hdr_pend = '{1'b1, 1'b1};
    idle_check("t1 idle after reset");

    // 2: first frame carries the header
    accept("t2", 8'hA5, 1'b0);
    chk("t2 frame bits", 32'(exp_bits.size()), 32'd15);
    check_frame("t2", -1, -1, 8'h00);
    idle_check("t2 end");

    // 3: second frame, no header, odd parity
    accept("t3", 8'h00, 1'b1);
    chk("t3 frame bits", 32'(exp_bits.size()), 32'd11);
    check_frame("t3", -1, -1, 8'h00);
    idle_check("t3 end");

    // 4: tx_start held with new data mid-frame
    accept("t4", 8'h3C, 1'b0);
    check_frame("t4a", -1, 50, 8'hC3);
    build_expected(data_in, ptype);
    idle_check("t4 gap");
    check_frame("t4b", -1, -1, 8'h00);
    idle_check("t4 end");

    // 5: reset mid-frame, header comes back
    accept("t5", 8'h96, 1'b1);
    check_frame("t5 partial", 40, -1, 8'h00);
    reset_pulse("t5 reset");
    accept("t5 after", 8'h81, 1'b0);
    chk("t5 header again", 32'(exp_bits.size()), 32'd15);
    check_frame("t5 after", -1, -1, 8'h00);
    idle_check("t5 end");

    // 6: 7-bit, no-parity configuration
    sel = 1'b1;
    idle_check("t6 idle");
    accept("t6", 8'h55, 1'b0);
    check_frame("t6", -1, -1, 8'h00);
    idle_check("t6 end");

    // randomized frames on both configurations
    for (int it = 0; it < 10; it++) begin
      sel = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 3);
      idle_check($sformatf("r%0d sel", it));
      for (int g = 0; g < gap; g++) idle_check($sformatf("r%0d gap%0d", it, g));
      d  = 8'($urandom);
      pt = 1'($urandom);
      accept($sformatf("r%0d", it), d, pt);
      if (it == 5) begin
        check_frame($sformatf("r%0d partial", it), $urandom_range(1, 30), -1, 8'h00);
        reset_pulse($sformatf("r%0d reset", it));
      end else begin
        check_frame($sformatf("r%0d d=%0h p=%0d", it, d, pt), -1, -1, 8'h00);
        idle_check($sformatf("r%0d end", it));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
